seg_serial_loader: RTL and testbench
====================================

# seg_serial_loader

Serial display loader that sits directly downstream of the periodic sync-pulse generator. On each rising edge of the sync pulse it snapshots a parallel display word (LED/segment pattern). It then shifts the word out MSB-first on a three-wire serial bus (shift clock, data, latch) to the board's external shift-register chain, and reports completion. One transfer runs per sync pulse. The pulse period (16384 clk cycles) is far longer than a transfer.

## Interface
- `WIDTH`, default 64: number of bits shifted per transfer; must be ≥ 1.
- `HALF`, default 2: clk cycles per serial-clock half-period; must be ≥ 1.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sync`  in  1  refresh request from the sync-pulse generator; level, typically high 8 cycles; only its rising edge is used.
- `data`  in  WIDTH  parallel display word; sampled only at transfer start.
- `s_clk`  out  1  serial shift clock to the external chain.
- `s_dat`  out  1  serial data, MSB first.
- `s_latch`  out  1  storage-register latch strobe, active high.
- `busy`  out  1  high from transfer start until the cycle `done` asserts.
- `done`  out  1  one-cycle pulse on transfer completion.

## Operation
- All outputs are registered. Reset values: `s_clk`=0, `s_dat`=0, `s_latch`=0, `busy`=0, `done`=0. Internal `sync_d`=0, FSM=IDLE, shift register=0, bit counter=0, half-period timer=0.
- Edge detect: `start` = `sync` & ~`sync_d` & (state==IDLE), where `sync_d` is `sync` delayed one cycle.
  - If `sync` is high in the first cycle after reset release, that counts as an edge.
  - Edges while not IDLE are discarded, not queued.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: `s_clk`=0, `s_dat`=0, `s_latch`=0, `busy`=0.
  - On `start`: shift register ← `data`, bit counter ← WIDTH, timer ← 0, go to SHIFT_LO.
- SHIFT_LO: `s_clk`=0, `s_dat`=shift register MSB, `busy`=1. After HALF cycles, go to SHIFT_HI.
- SHIFT_HI: `s_clk`=1, `s_dat` unchanged. After HALF cycles:
  - shift register shifts left by 1 (zero fill);
  - bit counter decrements;
  - if the counter reaches 0, go to LATCH; otherwise go to SHIFT_LO.
- LATCH: `s_clk`=0, `s_dat`=0, `s_latch`=1 for HALF cycles. Then go to IDLE with `done`=1 for exactly that first IDLE cycle.
- Timer counts 0..HALF-1 and clears on every state change. Timer width is clog2(HALF+1). Bit counter width is clog2(WIDTH+1); it never wraps.
- `data` changes after the snapshot have no effect on the current transfer.
- `rst` asserted in any state forces all reset values on the next edge:
  - the transfer is abandoned;
  - no `s_latch` and no `done` are produced.

## Timing
- Let the edge be detected in cycle T (`sync`=1, `sync_d`=0, IDLE). Then:
  - from T+1: state SHIFT_LO, `busy`=1, `s_dat` = `data`[WIDTH-1] as sampled in T;
  - bit k (k=0 is the MSB) occupies cycles T+1+2·HALF·k … T+2·HALF·(k+1);
  - `s_clk` rises HALF cycles into each bit period;
  - `s_dat` is stable for the whole bit period, giving HALF cycles of setup and HALF cycles of hold around each `s_clk` rise.
- `s_latch` is high over cycles T+1+2·HALF·WIDTH … T+2·HALF·WIDTH+HALF.
- `done`=1 and `busy`=0 at cycle T+1+2·HALF·WIDTH+HALF. With the defaults this is T+259.
- A `sync` rising edge in the `done` cycle is accepted, since the state is IDLE. Back-to-back transfers therefore have no dead cycle.
- Exactly WIDTH `s_clk` rising edges and one `s_latch` pulse occur per transfer.

## Test plan
- Basic transfer, defaults, `data`=64'h8000_0000_0000_0001, `sync` high 8 cycles → 64 `s_clk` rises. Sampled `s_dat` is 1, 62×0, 1. `s_latch` is high 2 cycles; `done` pulses once at T+259; `busy` is high T+1..T+258.
- Pattern integrity: `data`=64'hA5C3_0F1E_DEAD_BEEF; capture `s_dat` on each `s_clk` rise → reassembled word equals the input. `data` is changed to 0 at T+5 → output unaffected.
- Edge discipline: pulse `sync` again at T+100 while busy → ignored, one `done` only. Hold `sync` high continuously → exactly one transfer.
- Reset mid-operation: assert `rst` at T+50 for 1 cycle → next cycle all outputs 0, state IDLE. No `s_latch`/`done` occurs; a later `sync` edge starts a fresh full transfer.
- Back-to-back: raise `sync` in the `done` cycle → new transfer begins next cycle, `busy` high with no gap.
- Parameter corner: WIDTH=1, HALF=1, `data`=1 → `s_clk` high at T+2, `s_latch` at T+3, `done` at T+4.

Source files
------------

// File: rtl/seg_serial_loader_if.sv
// Bundle between the sync/data source and the serial display loader:
// refresh request and display word in, three-wire serial bus and status out.
interface seg_serial_loader_if #(
  parameter int WIDTH = 64
);
  logic             sync;
  logic [WIDTH-1:0] data;
  logic             s_clk;
  logic             s_dat;
  logic             s_latch;
  logic             busy;
  logic             done;

  modport master (
    output sync, data,
    input  s_clk, s_dat, s_latch, busy, done
  );

  modport slave (
    input  sync, data,
    output s_clk, s_dat, s_latch, busy, done
  );
endinterface

// File: rtl/seg_serial_loader.sv
// Snapshots a display word on each sync rising edge and shifts it MSB-first
// onto an external shift-register chain, then strobes the storage latch.
module seg_serial_loader #(
  parameter int WIDTH = 64,
  parameter int HALF  = 2
) (
  input  logic               clk,
  input  logic               rst,
  seg_serial_loader_if.slave bus
);

  localparam int TW = $clog2(HALF + 1);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t           state;
  logic             sync_d;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shl;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic             start;
  logic             half_done;

  // Edges seen while a transfer is running are dropped, not queued.
  assign start     = bus.sync & ~sync_d & (state == IDLE);
  assign half_done = (timer == TW'(HALF - 1));
  assign sreg_shl  = sreg << 1;

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // every branch assigns or holds state explicitly, so no latches arise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync_d      <= 1'b0;
      sreg        <= '0;
      cnt         <= '0;
      timer       <= '0;
      bus.s_clk   <= 1'b0;
      bus.s_dat   <= 1'b0;
      bus.s_latch <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      sync_d   <= bus.sync;
      bus.done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            sreg      <= bus.data;
            cnt       <= CW'(WIDTH);
            timer     <= '0;
            state     <= SHIFT_LO;
            bus.s_dat <= bus.data[WIDTH-1];
            bus.busy  <= 1'b1;
          end
        end

        SHIFT_LO: begin
          if (half_done) begin
            timer     <= '0;
            state     <= SHIFT_HI;
            bus.s_clk <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (half_done) begin
            timer     <= '0;
            sreg      <= sreg_shl;
            cnt       <= cnt - 1'b1;
            bus.s_clk <= 1'b0;
            if (cnt == CW'(1)) begin
              state       <= LATCH;
              bus.s_dat   <= 1'b0;
              bus.s_latch <= 1'b1;
            end else begin
              // Next bit goes out together with the falling s_clk.
              state     <= SHIFT_LO;
              bus.s_dat <= sreg_shl[WIDTH-1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        LATCH: begin
          if (half_done) begin
            timer       <= '0;
            state       <= IDLE;
            bus.s_latch <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_loader.sv
// Directed bench for seg_serial_loader: default 64-bit/HALF=2 instance plus
// a 1-bit/HALF=1 corner instance, sharing clock and reset.
module tb_seg_serial_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_serial_loader_if #(.WIDTH(64)) bus ();
  seg_serial_loader_if #(.WIDTH(1))  bus1 ();

  seg_serial_loader #(.WIDTH(64), .HALF(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seg_serial_loader #(.WIDTH(1), .HALF(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-transfer observations, filled by run_xfer.
  int          rises;
  int          latch_hi;
  int          first_latch;
  int          done_cnt;
  int          done_at;
  int          busy_err;
  logic [63:0] cap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer in cycle T (the current cycle) and observes T+1..T+ncyc.
  // Expected busy profile: T+1..T+258, plus T+260..T+517 for back-to-back.
  task automatic run_xfer(input logic [63:0] word, input int sync_len,
                          input int pulse_at, input int zero_at,
                          input bit b2b, input int ncyc);
    logic prev_clk;
    logic exp_busy;
    bus.sync = 1'b0;
    step();
    step();
    rises = 0; latch_hi = 0; first_latch = -1;
    done_cnt = 0; done_at = -1; busy_err = 0; cap = '0;
    prev_clk = bus.s_clk;
    bus.data = word;
    bus.sync = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      if (bus.s_clk && !prev_clk) begin
        rises++;
        cap = {cap[62:0], bus.s_dat};
      end
      prev_clk = bus.s_clk;
      if (bus.s_latch) begin
        latch_hi++;
        if (first_latch < 0) first_latch = k;
      end
      if (bus.done) begin
        done_cnt++;
        done_at = k;
      end
      exp_busy = (k <= 258) || (b2b && k >= 260 && k <= 517);
      if (bus.busy !== exp_busy) busy_err++;
      if (k == sync_len - 1) bus.sync = 1'b0;
      if (pulse_at > 0 && k == pulse_at) bus.sync = 1'b1;
      if (pulse_at > 0 && k == pulse_at + 4) bus.sync = 1'b0;
      if (zero_at > 0 && k == zero_at) bus.data = '0;
      if (b2b && k == 259) begin
        check("b2b_done_cycle", {63'd0, bus.done}, 64'd1);
        bus.sync = 1'b1;
      end
      if (b2b && k == 260) check("b2b_busy_no_gap", {63'd0, bus.busy}, 64'd1);
      if (b2b && k == 266) bus.sync = 1'b0;
    end
    bus.sync = 1'b0;
  endtask

  initial begin
    bus.sync  = 1'b0;
    bus.data  = '0;
    bus1.sync = 1'b0;
    bus1.data = '0;

    // Reset state
    repeat (3) step();
    check("rst_outputs", {59'd0, bus.s_clk, bus.s_dat, bus.s_latch, bus.busy, bus.done}, 64'd0);
    check("rst_outputs_w1", {59'd0, bus1.s_clk, bus1.s_dat, bus1.s_latch, bus1.busy, bus1.done}, 64'd0);
    rst = 1'b0;

    // Basic transfer
    run_xfer(64'h8000_0000_0000_0001, 8, -1, -1, 1'b0, 270);
    check("basic_rises", rises, 64);
    check("basic_word", cap, 64'h8000_0000_0000_0001);
    check("basic_latch_len", latch_hi, 2);
    check("basic_latch_start", first_latch, 257);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_at", done_at, 259);
    check("basic_busy_errs", busy_err, 0);

    // Pattern integrity with data cleared at T+5
    run_xfer(64'hA5C3_0F1E_DEAD_BEEF, 8, -1, 5, 1'b0, 270);
    check("pat_word", cap, 64'hA5C3_0F1E_DEAD_BEEF);
    check("pat_rises", rises, 64);
    check("pat_done_at", done_at, 259);

    // Second edge at T+100 while busy is ignored
    run_xfer(64'h0123_4567_89AB_CDEF, 8, 100, -1, 1'b0, 400);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_rises", rises, 64);
    check("ign_word", cap, 64'h0123_4567_89AB_CDEF);
    check("ign_busy_errs", busy_err, 0);

    // Sync held high throughout: one transfer only
    run_xfer(64'hFFFF_0000_FFFF_0000, 1000, -1, -1, 1'b0, 600);
    check("hold_done_cnt", done_cnt, 1);
    check("hold_rises", rises, 64);
    check("hold_latch_len", latch_hi, 2);

    // Back-to-back transfer started in the done cycle
    run_xfer(64'h5A5A_5A5A_C3C3_C3C3, 8, -1, -1, 1'b1, 530);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_done_at", done_at, 518);
    check("b2b_rises", rises, 128);
    check("b2b_latch_len", latch_hi, 4);
    check("b2b_word", cap, 64'h5A5A_5A5A_C3C3_C3C3);
    check("b2b_busy_errs", busy_err, 0);

    // Reset at T+50 abandons the transfer
    step();
    step();
    bus.data = 64'hDEAD_BEEF_0000_FFFF;
    bus.sync = 1'b1;
    latch_hi = 0;
    done_cnt = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 7) bus.sync = 1'b0;
    end
    check("mid_busy_before_rst", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_outputs", {59'd0, bus.s_clk, bus.s_dat, bus.s_latch, bus.busy, bus.done}, 64'd0);
    busy_err = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (bus.s_latch) latch_hi++;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_err++;
    end
    check("mid_no_latch", latch_hi, 0);
    check("mid_no_done", done_cnt, 0);
    check("mid_stays_idle", busy_err, 0);

    run_xfer(64'h1357_9BDF_2468_ACE0, 8, -1, -1, 1'b0, 270);
    check("post_rst_word", cap, 64'h1357_9BDF_2468_ACE0);
    check("post_rst_done_at", done_at, 259);
    check("post_rst_busy_errs", busy_err, 0);

    // WIDTH=1, HALF=1 corner
    step();
    bus1.data = 1'b1;
    bus1.sync = 1'b1;
    step();
    bus1.sync = 1'b0;
    check("w1_t1", {60'd0, bus1.s_clk, bus1.s_dat, bus1.s_latch, bus1.busy}, 64'b0101);
    step();
    check("w1_t2_sclk", {60'd0, bus1.s_clk, bus1.s_dat, bus1.s_latch, bus1.busy}, 64'b1101);
    step();
    check("w1_t3_latch", {60'd0, bus1.s_clk, bus1.s_latch, bus1.busy, bus1.done}, 64'b0110);
    step();
    check("w1_t4_done", {60'd0, bus1.s_clk, bus1.s_latch, bus1.busy, bus1.done}, 64'b0001);
    step();
    check("w1_t5_idle", {60'd0, bus1.s_clk, bus1.s_latch, bus1.busy, bus1.done}, 64'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
